// File: rtl/twotone_sample_gen.sv
// twotone_sample_gen: two phase-accumulator tones from a shared sine ROM, scaled, summed and saturated.
// Define QUARTER_LUT_EN to store only a quarter-wave table (N/4+1 entries) instead of the full period.
`default_nettype none

module twotone_sample_gen #(
  parameter int NB_OUTPUT   = 8,
  parameter int NBF_OUTPUT  = 7,
  parameter int NB_PHASE    = 16,
  parameter int NB_LUT_ADDR = 8,
  parameter int CLK_DIV     = 4
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_phase_clr,
  input  logic [NB_PHASE-1:0]         i_fcw_a,
  input  logic [NB_PHASE-1:0]         i_fcw_b,
  input  logic [1:0]                  i_sh_a,
  input  logic [1:0]                  i_sh_b,
  output logic signed [NB_OUTPUT-1:0] o_os_data,
  output logic                        o_valid
);

  localparam int  N     = 2 ** NB_LUT_ADDR;
  localparam int  CNT_W = $clog2(CLK_DIV);
  localparam real AMP   = real'(2 ** (NB_OUTPUT - 1) - 1);
  localparam real PI    = 3.14159265358979323846;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic signed [NB_OUTPUT-1:0] SAT_MAX = {1'b0, {(NB_OUTPUT-1){1'b1}}};
  localparam logic signed [NB_OUTPUT-1:0] SAT_MIN = {1'b1, {(NB_OUTPUT-1){1'b0}}};

  if (CLK_DIV < 3 || NBF_OUTPUT >= NB_OUTPUT || NB_LUT_ADDR < 3) begin : g_bad_params
    $error("twotone_sample_gen: unsupported parameter combination");
  end

  // Round half away from zero so the table is exactly odd-symmetric.
  function automatic logic signed [NB_OUTPUT-1:0] sine_entry(input int k);
    real x;
    x = AMP * $sin(2.0 * PI * real'(k) / real'(N));
    if (x >= 0.0) return NB_OUTPUT'($rtoi(x + 0.5));
    else          return NB_OUTPUT'(-$rtoi(0.5 - x));
  endfunction

  logic [CNT_W-1:0]           cnt;
  logic [NB_PHASE-1:0]        ph_a, ph_b;
  logic                       tick, take;
  logic signed [NB_OUTPUT-1:0] lut_a, lut_b;
  logic signed [NB_OUTPUT-1:0] raw_a, raw_b, scl_a, scl_b;
  logic                       v0, v1;
  logic signed [NB_OUTPUT:0]  sum;
  logic signed [NB_OUTPUT-1:0] sat;

`ifdef QUARTER_LUT_EN
  localparam int Q = N / 4;
  logic signed [NB_OUTPUT-1:0] rom [Q+1];

  for (genvar k = 0; k <= Q; k++) begin : g_rom
    localparam logic signed [NB_OUTPUT-1:0] C_VAL = sine_entry(k);
    assign rom[k] = C_VAL;
  end

  // Quadrant bits: odd quadrants mirror the index, the upper half negates.
  function automatic logic signed [NB_OUTPUT-1:0] lut_read(input logic [NB_LUT_ADDR-1:0] addr);
    logic [NB_LUT_ADDR-2:0]      idx;
    logic signed [NB_OUTPUT-1:0] val;
    idx = {1'b0, addr[NB_LUT_ADDR-3:0]};
    if (addr[NB_LUT_ADDR-2]) idx = (NB_LUT_ADDR-1)'(Q) - idx;
    val = rom[idx];
    return addr[NB_LUT_ADDR-1] ? -val : val;
  endfunction
`else
  logic signed [NB_OUTPUT-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam logic signed [NB_OUTPUT-1:0] C_VAL = sine_entry(k);
    assign rom[k] = C_VAL;
  end

  function automatic logic signed [NB_OUTPUT-1:0] lut_read(input logic [NB_LUT_ADDR-1:0] addr);
    return rom[addr];
  endfunction
`endif

  always_comb begin
    lut_a = lut_read(ph_a[NB_PHASE-1 -: NB_LUT_ADDR]);
    lut_b = lut_read(ph_b[NB_PHASE-1 -: NB_LUT_ADDR]);
  end

  assign tick = (cnt == CNT_LAST) && i_en;
  assign take = tick && !i_phase_clr;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      ph_a <= '0;
      ph_b <= '0;
    end else if (i_phase_clr) begin
      cnt  <= '0;
      ph_a <= '0;
      ph_b <= '0;
    end else if (i_en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        ph_a <= ph_a + i_fcw_a;
        ph_b <= ph_b + i_fcw_b;
      end
    end
  end

  always_comb begin
    sum = $signed({scl_a[NB_OUTPUT-1], scl_a}) + $signed({scl_b[NB_OUTPUT-1], scl_b});
    sat = sum[NB_OUTPUT-1:0];
    if (sum[NB_OUTPUT] != sum[NB_OUTPUT-1]) sat = sum[NB_OUTPUT] ? SAT_MIN : SAT_MAX;
  end

  // Three-register pipeline: registered ROM read, shift, saturated sum.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      raw_a     <= '0;
      raw_b     <= '0;
      scl_a     <= '0;
      scl_b     <= '0;
      o_valid   <= 1'b0;
      o_os_data <= '0;
    end else begin
      v0      <= take;
      v1      <= v0;
      o_valid <= v1;
      if (take) begin
        raw_a <= lut_a;
        raw_b <= lut_b;
      end
      if (v0) begin
        scl_a <= raw_a >>> i_sh_a;
        scl_b <= raw_b >>> i_sh_b;
      end
      if (v1) o_os_data <= sat;
    end
  end

endmodule

`default_nettype wire
